// File: rtl/psram_pkg.sv
// Shared types and helpers for the PSRAM single-line read buffer.
// Holds the FSM state enum, the transfer size codes and lane-mask helpers.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_ISSUE,
        ST_FILL_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT
    } state_t;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // Anything that is not a byte or halfword is handled as a full word.
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        logic [2:0] s;
        s = SZ_WORD;
        unique case (1'b1)
            (size == SZ_BYTE): s = SZ_BYTE;
            (size == SZ_HALF): s = SZ_HALF;
            default:           s = SZ_WORD;
        endcase
        return s;
    endfunction

    // Byte lanes covered by an access of the given size at offset off.
    function automatic logic [3:0] byte_mask(input logic [1:0] off,
                                             input logic [2:0] size);
        logic [3:0] m;
        m = 4'hF;
        unique case (1'b1)
            (size == SZ_BYTE): m = 4'b0001 << off;
            (size == SZ_HALF): m = off[1] ? 4'b1100 : 4'b0011;
            default:           m = 4'hF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/psram_line_store.sv
// Data storage for the buffered line: LINE_WORDS x 32-bit registers.
// Ports: fill_* whole-word write, wr_* byte-enabled write, rd_* comb read.
module psram_line_store #(
    parameter  int LINE_WORDS = 4,
    localparam int IW         = $clog2(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          fill_we,
    input  logic [IW-1:0] fill_idx,
    input  logic [31:0]   fill_data,
    input  logic [3:0]    wr_be,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [LINE_WORDS];

    // Fill and byte writes happen in different FSM states; fill has priority.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_idx] <= fill_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/psram_read_buffer.sv
// Single-line read buffer with write-through in front of the PSRAM controller.
// Ports: clk/rst, flush, front req/ack bus, mc_* start/done controller bus.
module psram_read_buffer
    import psram_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int AW         = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic [31:0]   req_wdata,
    output logic          ack,
    output logic [31:0]   rdata,
    output logic          mc_start,
    output logic [AW-1:0] mc_addr,
    output logic [2:0]    mc_size,
    output logic          mc_rd_wr,
    output logic [31:0]   mc_wdata,
    input  logic [31:0]   mc_rdata,
    input  logic          mc_done
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int TW = AW - IW - 2;
    localparam logic [IW-1:0] IDX_LAST = IW'(LINE_WORDS - 1);
    localparam logic [IW-1:0] IDX_ZERO = '0;

    state_t        state_q, state_d;
    logic          valid_q;
    logic [TW-1:0] tag_q;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_nxt;
    logic          pend_flush_q;

    logic [1:0]    req_off;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          active;
    logic          hit;
    logic          in_fill;

    logic          fill_we;
    logic [3:0]    wr_be;
    logic          fill_start;
    logic          cnt_inc;
    logic          fill_done;
    logic          ld_wr;
    logic          ack_d;
    logic          rd_upd;
    logic [31:0]   line_rd;
    logic [31:0]   rd_word;

    assign req_off = req_addr[1:0];
    assign req_idx = req_addr[IW+1:2];
    assign req_tag = req_addr[AW-1:IW+2];
    assign cnt_nxt = cnt_q + IW'(1);

    // A request stays up through its ack cycle; do not serve it twice.
    assign active  = req & ~ack;
    assign hit     = valid_q & (tag_q == req_tag);
    assign in_fill = (state_q == ST_FILL_ISSUE) | (state_q == ST_FILL_WAIT);

    assign mc_start = (state_q == ST_FILL_ISSUE) | (state_q == ST_WR_ISSUE);

    // The word landing this cycle is not yet in the store; bypass it.
    assign rd_word = (fill_we && (cnt_q == req_idx)) ? mc_rdata : line_rd;

    psram_line_store #(
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .clk       (clk),
        .fill_we   (fill_we),
        .fill_idx  (cnt_q),
        .fill_data (mc_rdata),
        .wr_be     (wr_be),
        .wr_idx    (req_idx),
        .wr_data   (req_wdata),
        .rd_idx    (req_idx),
        .rd_data   (line_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_we    = 1'b0;
        wr_be      = 4'b0000;
        fill_start = 1'b0;
        cnt_inc    = 1'b0;
        fill_done  = 1'b0;
        ld_wr      = 1'b0;
        ack_d      = 1'b0;
        rd_upd     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (active) begin
                    if (req_we) begin
                        state_d = ST_WR_ISSUE;
                        ld_wr   = 1'b1;
                        if (hit && !flush) begin
                            wr_be = byte_mask(req_off, norm_size(req_size));
                        end
                    end else if (hit && !flush) begin
                        ack_d  = 1'b1;
                        rd_upd = 1'b1;
                    end else begin
                        state_d    = ST_FILL_ISSUE;
                        fill_start = 1'b1;
                    end
                end
            end
            ST_FILL_ISSUE: begin
                state_d = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (mc_done) begin
                    fill_we = 1'b1;
                    if (cnt_q == IDX_LAST) begin
                        state_d   = ST_IDLE;
                        fill_done = 1'b1;
                        ack_d     = 1'b1;
                        rd_upd    = 1'b1;
                    end else begin
                        state_d = ST_FILL_ISSUE;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_WR_ISSUE: begin
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mc_done) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            tag_q        <= '0;
            cnt_q        <= '0;
            pend_flush_q <= 1'b0;
            ack          <= 1'b0;
            rdata        <= '0;
            mc_addr      <= '0;
            mc_size      <= SZ_WORD;
            mc_rd_wr     <= 1'b1;
            mc_wdata     <= '0;
        end else begin
            ack <= ack_d;
            if (rd_upd) begin
                rdata <= rd_word;
            end
            if (fill_start) begin
                valid_q  <= 1'b0;
                tag_q    <= req_tag;
                cnt_q    <= '0;
                mc_addr  <= {req_tag, IDX_ZERO, 2'b00};
                mc_size  <= SZ_WORD;
                mc_rd_wr <= 1'b1;
            end
            if (cnt_inc) begin
                cnt_q   <= cnt_nxt;
                mc_addr <= {tag_q, cnt_nxt, 2'b00};
            end
            if (ld_wr) begin
                mc_addr  <= req_addr;
                mc_size  <= norm_size(req_size);
                mc_rd_wr <= 1'b0;
                mc_wdata <= req_wdata;
            end
            // A flush seen during a fill is deferred until the fill ends.
            if (fill_done) begin
                valid_q      <= ~(pend_flush_q | flush);
                pend_flush_q <= 1'b0;
            end else if (flush) begin
                if (in_fill) begin
                    pend_flush_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

endmodule
